axi4_led_pwm: RTL and testbench

AXI4_LED_PWM -- requirements
Module: axi4_led_pwm

---
 rtl/axi4_led_pwm.sv | 214 +++++++++++++++++++++
 tb/tb_axi4_led_pwm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_led_pwm.sv
// AXI4-Lite controlled LED driver: per-channel off/on/blink/pwm modes,
// a shared prescaled tick, global enable and output inversion.
module axi4_led_pwm #(
    parameter int NUM_LEDS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_LEDS-1:0]               led_o
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    // Handshake: a channel completes on the edge where its valid and ready
    // are both high. awready/wready (and arready) are single-cycle pulses
    // raised only when the request is present and no response is pending;
    // bvalid/rvalid rise the cycle after and hold until bready/rready.

    logic            r_awready;
    logic            r_arready;
    logic            r_bvalid;
    logic            r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic [1:0]      r_ctrl;
    logic [15:0]     r_prescale;
    logic [15:0]     r_tick_cnt;
    logic [7:0]      r_phase;
    logic [1:0]      r_mode      [NUM_LEDS];
    logic [7:0]      r_duty      [NUM_LEDS];
    logic [7:0]      r_half      [NUM_LEDS];
    logic [7:0]      r_blink_cnt [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_blink_st;
    logic [NUM_LEDS-1:0] r_led;

    logic            w_wr_en;
    logic            w_rd_en;
    logic [IW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_rd_idx;
    logic            w_tick;
    logic            w_pre_wr;
    logic [DW-1:0]   w_rd_data;
    logic [NUM_LEDS-1:0] w_raw;
    logic            w_unused_ok;

    assign w_wr_en  = r_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign w_rd_en  = r_arready & s00_axi_arvalid;
    assign w_wr_idx = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_tick   = (r_tick_cnt == r_prescale);
    assign w_pre_wr = w_wr_en & (w_wr_idx == IW'(1)) & (|s00_axi_wstrb[1:0]);

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_awready;
    assign s00_axi_arready = r_arready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;
    assign led_o           = r_led;

    // Protection bits, byte offsets and bits outside any field are ignored.
    assign w_unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                           s00_axi_wdata[DW-1:24], s00_axi_wdata[7:2],
                           s00_axi_wstrb[DW/8-1:3]};

    // AXI handshake pulses and response holding registers
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid & ~r_awready;
            r_arready <= s00_axi_arvalid & ~r_rvalid & ~r_arready;
            if (w_wr_en)
                r_bvalid <= 1'b1;
            else if (s00_axi_bready)
                r_bvalid <= 1'b0;
            if (w_rd_en) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Read mux; reserved and unmapped words return zero
    always_comb begin
        w_rd_data = '0;
        if (w_rd_idx == IW'(0))
            w_rd_data = DW'(r_ctrl);
        else if (w_rd_idx == IW'(1))
            w_rd_data = DW'(r_prescale);
        else if (w_rd_idx == IW'(2))
            w_rd_data = DW'(r_led);
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_rd_idx == IW'(4 + i))
                w_rd_data = DW'({r_half[i], r_duty[i], 6'b0, r_mode[i]});
        end
    end

    // Register writes; every field sits inside one byte lane so wstrb gates it directly
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_mode[i] <= '0;
                r_duty[i] <= '0;
                r_half[i] <= '0;
            end
        end else if (w_wr_en) begin
            if (w_wr_idx == IW'(0) && s00_axi_wstrb[0])
                r_ctrl <= s00_axi_wdata[1:0];
            if (w_wr_idx == IW'(1)) begin
                if (s00_axi_wstrb[0]) r_prescale[7:0]  <= s00_axi_wdata[7:0];
                if (s00_axi_wstrb[1]) r_prescale[15:8] <= s00_axi_wdata[15:8];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr_idx == IW'(4 + i)) begin
                    if (s00_axi_wstrb[0]) r_mode[i] <= s00_axi_wdata[1:0];
                    if (s00_axi_wstrb[1]) r_duty[i] <= s00_axi_wdata[15:8];
                    if (s00_axi_wstrb[2]) r_half[i] <= s00_axi_wdata[23:16];
                end
            end
        end
    end

    // Prescaled tick counter and the shared PWM phase
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_tick_cnt <= '0;
            r_phase    <= '0;
        end else begin
            if (w_pre_wr || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 16'd1;
            if (w_tick)
                r_phase <= r_phase + 8'd1;
        end
    end

    // Per-channel blink; >= rather than == so shrinking the half-period
    // mid-blink never lets the counter run past its terminal value
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_blink_st <= '0;
            for (int i = 0; i < NUM_LEDS; i++)
                r_blink_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (r_mode[i] != 2'd2) begin
                    r_blink_cnt[i] <= '0;
                    r_blink_st[i]  <= 1'b0;
                end else if (w_tick) begin
                    if (r_blink_cnt[i] >= ((r_half[i] == 8'd0) ? 8'd0 : r_half[i] - 8'd1)) begin
                        r_blink_cnt[i] <= '0;
                        r_blink_st[i]  <= ~r_blink_st[i];
                    end else begin
                        r_blink_cnt[i] <= r_blink_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // Mode-derived raw level for each channel
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (r_mode[i])
                2'd1:    w_raw[i] = 1'b1;
                2'd2:    w_raw[i] = r_blink_st[i];
                2'd3:    w_raw[i] = (r_phase < r_duty[i]);
                default: w_raw[i] = 1'b0;
            endcase
        end
    end

    // Registered LED output with global enable then inversion
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn)
            r_led <= '0;
        else
            r_led <= (w_raw & {NUM_LEDS{r_ctrl[0]}}) ^ {NUM_LEDS{r_ctrl[1]}};
    end

endmodule

// File: tb/tb_axi4_led_pwm.sv
// Bench for axi4_led_pwm: register access, LED modes, handshake corner cases
// and reset behaviour. Read data expectations go through exp_q.
module tb_axi4_led_pwm;
    localparam int LIM = 40;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [6:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [6:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  led_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    axi4_led_pwm dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .led_o           (led_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Starts on a negedge with awvalid/wvalid raised; returns on the negedge where bvalid is seen
    task automatic wr_issue(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < LIM) begin @(negedge clk); n++; end
        chk("aw_wait", 32'(n < LIM), 1);
        chk("wready", 32'(wready), 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < LIM) begin @(negedge clk); n++; end
        chk("b_wait", 32'(n < LIM), 1);
        chk("bresp", 32'(bresp), 0);
    endtask

    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bready = 1'b1;
        wr_issue(addr, data, strb);
    endtask

    task automatic axi_read(input logic [6:0] addr, input logic [31:0] exp);
        int n;
        logic [31:0] e;
        exp_q.push_back(exp);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < LIM) begin @(negedge clk); n++; end
        chk("ar_wait", 32'(n < LIM), 1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < LIM) begin @(negedge clk); n++; end
        chk("r_wait", 32'(n < LIM), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("rd_%02h", addr), rdata, e);
        end
        chk("rresp", 32'(rresp), 0);
    endtask

    // Find a rising edge of channel 2, count high cycles over one period, confirm the next rise
    task automatic pwm_meas(input int exp_hi, input string tag);
        int n;
        int hi;
        logic prev, cur, rise, last;
        prev = led_o[2]; n = 0; rise = 1'b0;
        while (!rise && n < 600) begin
            @(negedge clk); n++;
            cur = led_o[2]; rise = cur & ~prev; prev = cur;
        end
        chk({tag, "_find"}, 32'(rise), 1);
        hi = 1;
        for (int k = 1; k < 256; k++) begin
            @(negedge clk);
            hi += int'(led_o[2]);
        end
        chk({tag, "_high"}, 32'(hi), 32'(exp_hi));
        last = led_o[2];
        @(negedge clk);
        chk({tag, "_period"}, {30'd0, last, led_o[2]}, 32'b01);
    endtask

    // After the first toggle, measure two full toggle intervals
    task automatic meas_toggle(input int idx, input int exp_per, input string tag);
        int n;
        logic prev;
        prev = led_o[idx]; n = 0;
        while (led_o[idx] == prev && n < 100) begin @(negedge clk); n++; end
        chk({tag, "_first"}, 32'(n < 100), 1);
        for (int r = 0; r < 2; r++) begin
            prev = led_o[idx]; n = 0;
            while (led_o[idx] == prev && n < 100) begin @(negedge clk); n++; end
            chk(tag, 32'(n), 32'(exp_per));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hs", {27'd0, awready, wready, arready, bvalid, rvalid}, 0);
        chk("rst_led", 32'(led_o), 0);
        chk("rst_rdata", rdata, 0);
        aresetn = 1'b1;

        for (int a = 0; a < 8; a++) axi_read(7'(a * 4), 0);
        chk("led_idle", 32'(led_o), 0);

        // Static on, output latency, status and inversion
        axi_write(7'h00, 32'h1, 4'hF);
        axi_write(7'h10, 32'h1, 4'hF);
        chk("led_lat", 32'(led_o), 0);
        @(negedge clk);
        chk("led_on", 32'(led_o), 32'b0001);
        axi_write(7'h14, 32'h0, 4'hF);
        axi_read(7'h08, 32'h1);
        axi_write(7'h00, 32'h3, 4'hF);
        @(negedge clk);
        chk("led_inv", 32'(led_o), 32'b1110);
        axi_read(7'h00, 32'h3);

        // PWM on channel 2, tick every cycle
        axi_write(7'h00, 32'h1, 4'hF);
        axi_write(7'h04, 32'h0, 4'hF);
        axi_write(7'h18, 32'h0003_4003, 4'hF);
        axi_read(7'h18, 32'h0003_4003);
        pwm_meas(64, "pwm40");
        axi_write(7'h18, 32'h0003_FF03, 4'hF);
        pwm_meas(255, "pwmff");

        // Blink on channel 3 with tick every other cycle
        axi_write(7'h04, 32'h1, 4'hF);
        axi_write(7'h1C, 32'h0003_0002, 4'hF);
        meas_toggle(3, 6, "blink6");
        axi_write(7'h1C, 32'h0000_0002, 4'hF);
        meas_toggle(3, 2, "blink2");

        // Byte strobes, zero strobe, reserved/unmapped/status writes
        axi_write(7'h10, 32'hFFFF_FFFF, 4'b0010);
        axi_read(7'h10, 32'h0000_FF01);
        axi_write(7'h00, 32'h0, 4'b0000);
        axi_read(7'h00, 32'h1);
        axi_write(7'h0C, 32'hFFFF_FFFF, 4'hF);
        axi_write(7'h20, 32'hFFFF_FFFF, 4'hF);
        axi_write(7'h08, 32'hFFFF_FFFF, 4'hF);
        axi_read(7'h0C, 32'h0);
        axi_read(7'h20, 32'h0);
        axi_read(7'h04, 32'h1);

        // Address without data is not accepted; response held while bready low
        awaddr = 7'h14; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("aw_alone", 32'(awready), 0);
        end
        wr_issue(7'h14, 32'h1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_hold", 32'(bvalid), 1);
        end
        bready = 1'b1;
        @(negedge clk);
        chk("b_clear", 32'(bvalid), 0);
        axi_read(7'h14, 32'h1);

        // Simultaneous accept: read sees the value from before the write
        repeat (2) @(negedge clk);
        fork
            axi_write(7'h00, 32'h3, 4'hF);
            axi_read(7'h00, 32'h1);
        join
        axi_read(7'h00, 32'h3);

        // Reset with a response pending and channel 3 blinking
        bready = 1'b0;
        wr_issue(7'h04, 32'h7, 4'hF);
        aresetn = 1'b0;
        @(negedge clk);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_led_mid", 32'(led_o), 0);
        aresetn = 1'b1;
        bready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_resp", {30'd0, bvalid, rvalid}, 0);
        chk("post_rst_led", 32'(led_o), 0);
        axi_read(7'h04, 32'h0);
        axi_read(7'h1C, 32'h0);
        axi_read(7'h7C, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
